// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the sequential FIR MAC stage.
// Tap and coefficient words are signed Q1.15; the accumulator holds Q2.30 sums.
package fir_pkg;

   localparam int TAP_W  = 16;
   localparam int COEF_W = 16;
   localparam int PROD_W = TAP_W + COEF_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Round half-up, drop frac bits, clamp to signed 16 bits.
   // Callers sign-extend their accumulator to 64 bits, so any ACC_W <= 64 works.
   function automatic logic signed [15:0] round_sat(input logic signed [63:0] acc,
                                                    input int                 frac);
      logic signed [63:0] half;
      logic signed [63:0] shifted;
      logic signed [15:0] res;
      half    = 64'sd1 <<< (frac - 1);
      shifted = (acc + half) >>> frac;
      if (shifted > 64'sd32767) begin
         res = 16'sh7fff;
      end else if (shifted < -64'sd32768) begin
         res = 16'sh8000;
      end else begin
         res = shifted[15:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_coef_rf.sv
// N-entry signed Q1.15 coefficient register file with a gated, range-checked
// write port and a combinational read port driven by the MAC tap index.
module fir_coef_rf
   import fir_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic                      en,
   input  logic [$clog2(N)-1:0]      waddr,
   input  logic signed [COEF_W-1:0]  wdata,
   input  logic [$clog2(N)-1:0]      raddr,
   output logic signed [COEF_W-1:0]  rdata
);

   logic signed [COEF_W-1:0] mem [0:N-1];
   logic                     in_range;
   logic                     wr_ok;

   // Non-power-of-two N leaves address codes with no backing entry.
   assign in_range = (32'(waddr) < 32'(N));
   assign wr_ok    = we && en && in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR multiply-accumulate: one tap per clock on a single 16x16
// multiplier, then one rounded/saturated Q1.15 output per accepted start.
//
// state | meaning
// IDLE  | ready; start clears acc/k and begins a run, coefficient writes allowed
// MAC   | acc += taps_in[k]*coef[k], k++; leaves after k = N-1
// OUT   | latch round_sat(acc) into y_out and pulse y_valid
module fir_mac_seq
   import fir_pkg::*;
#(
   parameter int N     = 8,
   parameter int ACC_W = 40,
   parameter int FRAC  = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic signed [TAP_W-1:0]   taps_in [0:N-1],
   input  logic                      coef_we,
   input  logic [$clog2(N)-1:0]      coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   output logic                      ready,
   output logic                      busy,
   output logic signed [15:0]        y_out,
   output logic                      y_valid
);

   localparam int K_W = $clog2(N);

   state_t                    state;
   state_t                    state_nx;
   logic [K_W-1:0]            k;
   logic signed [ACC_W-1:0]   acc;
   logic signed [COEF_W-1:0]  coef_rd;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic                      acc_clr;
   logic                      acc_en;
   logic                      out_ld;

   fir_coef_rf #(
      .N (N)
   ) u_coef_rf (
      .clk   (clk),
      .rst   (rst),
      .we    (coef_we),
      .en    (ready),
      .waddr (coef_addr),
      .wdata (coef_data),
      .raddr (k),
      .rdata (coef_rd)
   );

   assign prod     = taps_in[k] * coef_rd;
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   assign ready = (state == IDLE);
   assign busy  = ~ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;
      out_ld   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               acc_clr  = 1'b1;
               state_nx = MAC;
            end
         end
         MAC: begin
            acc_en = 1'b1;
            if (k == K_W'(N-1)) begin
               state_nx = OUT;
            end
         end
         OUT: begin
            out_ld   = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         k       <= '0;
         y_out   <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= out_ld;
         if (acc_clr) begin
            acc <= '0;
            k   <= '0;
         end else if (acc_en) begin
            acc <= acc + prod_ext;
            k   <= k + 1'b1;
         end
         if (out_ld) begin
            y_out <= round_sat(64'(acc), FRAC);
         end
      end
   end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq (N=8): reset, latency/value, saturation,
// rounding, busy-time rules and asynchronous reset in the middle of a run.
module tb_fir_mac_seq;

   localparam int N = 8;

   logic               clk;
   logic               rst;
   logic               start;
   logic signed [15:0] taps [0:N-1];
   logic               coef_we;
   logic [2:0]         coef_addr;
   logic signed [15:0] coef_data;
   logic               ready;
   logic               busy;
   logic signed [15:0] y_out;
   logic               y_valid;

   int checks   = 0;
   int failures = 0;

   fir_mac_seq #(
      .N     (N),
      .ACC_W (40),
      .FRAC  (15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .taps_in   (taps),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .ready     (ready),
      .busy      (busy),
      .y_out     (y_out),
      .y_valid   (y_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic set_coefs(input logic [15:0] c0, input logic [15:0] rest);
      write_coef(3'd0, c0);
      for (int i = 1; i < N; i++) begin
         write_coef(3'(i), rest);
      end
   endtask

   task automatic set_taps(input logic [15:0] t0, input logic [15:0] rest);
      taps[0] = t0;
      for (int i = 1; i < N; i++) begin
         taps[i] = rest;
      end
   endtask

   // Pulses start for one edge and counts edges until y_valid is seen (bounded).
   task automatic run_once(output int lat);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (y_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int lat;
      rst = 1'b1;
      #3;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || y_valid !== 1'b0 || y_out !== 16'h0000) begin
         failures++;
         $display("FAIL reset_outputs: ready=%b busy=%b y_valid=%b y_out=%h, need 1 0 0 0000",
                  ready, busy, y_valid, y_out);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || y_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: ready=%b busy=%b y_valid=%b, need 1 0 0",
                  ready, busy, y_valid);
      end
      set_taps(16'hFFFF, 16'hFFFF);
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h0000) begin
         failures++;
         $display("FAIL reset_coefs_zero: lat=%0d y_out=%h, need 9 0000", lat, y_out);
      end
   endtask

   task automatic test_latency();
      int lat;
      set_coefs(16'h4000, 16'h0000);
      set_taps(16'h1234, 16'h7FFF);
      run_once(lat);
      checks++;
      if (lat !== 9) begin
         failures++;
         $display("FAIL latency: got %0d clocks, need 9", lat);
      end
      checks++;
      if (y_out !== 16'h091A) begin
         failures++;
         $display("FAIL latency_value: y_out=%h, need 091a", y_out);
      end
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ready_in_valid_cycle: ready=%b busy=%b, need 1 0", ready, busy);
      end
      tick();
      checks++;
      if (y_valid !== 1'b0 || y_out !== 16'h091A) begin
         failures++;
         $display("FAIL pulse_width: y_valid=%b y_out=%h, need 0 091a", y_valid, y_out);
      end
   endtask

   task automatic test_saturation();
      int lat;
      set_coefs(16'h4000, 16'h4000);
      set_taps(16'h2000, 16'h2000);
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h7FFF) begin
         failures++;
         $display("FAIL sat_pos: lat=%0d y_out=%h, need 9 7fff", lat, y_out);
      end
      set_taps(16'hC000, 16'hC000);
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h8000) begin
         failures++;
         $display("FAIL sat_neg: lat=%0d y_out=%h, need 9 8000", lat, y_out);
      end
   endtask

   task automatic test_rounding();
      int lat;
      set_coefs(16'h0001, 16'h0000);
      set_taps(16'h4000, 16'h0000);
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h0001) begin
         failures++;
         $display("FAIL round_half_up: lat=%0d y_out=%h, need 9 0001", lat, y_out);
      end
      set_taps(16'h3FFF, 16'h0000);
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h0000) begin
         failures++;
         $display("FAIL round_below_half: lat=%0d y_out=%h, need 9 0000", lat, y_out);
      end
      // Negative half rounds toward +inf: -0x4000 * 1 -> -0.5 LSB -> 0
      set_taps(16'hC000, 16'h0000);
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h0000) begin
         failures++;
         $display("FAIL round_neg_half: lat=%0d y_out=%h, need 9 0000", lat, y_out);
      end
   endtask

   task automatic test_busy_rules();
      int  lat;
      bit  seen;
      set_coefs(16'h4000, 16'h0000);
      set_taps(16'h1234, 16'h0000);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      tick();
      tick();
      tick();
      // k=3 now: stray start and coefficient write must both be ignored
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
         failures++;
         $display("FAIL busy_mid_run: busy=%b ready=%b, need 1 0", busy, ready);
      end
      start     = 1'b1;
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 16'h7FFF;
      tick();
      start   = 1'b0;
      coef_we = 1'b0;
      for (int c = 5; c <= 40; c++) begin
         tick();
         if (y_valid) begin
            lat = c;
            break;
         end
      end
      checks++;
      if (lat !== 9 || y_out !== 16'h091A) begin
         failures++;
         $display("FAIL start_ignored_busy: lat=%0d y_out=%h, need 9 091a", lat, y_out);
      end
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (y_valid || !ready) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL no_queued_start: extra activity=%b, need 0", seen);
      end
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h091A) begin
         failures++;
         $display("FAIL busy_write_dropped: lat=%0d y_out=%h, need 9 091a", lat, y_out);
      end
      // Back-to-back: accept a new start in the y_valid cycle
      set_taps(16'h2000, 16'h0000);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (y_valid) begin
            lat = c;
            break;
         end
      end
      checks++;
      if (lat !== 9 || y_out !== 16'h1000) begin
         failures++;
         $display("FAIL back_to_back: lat=%0d y_out=%h, need 9 1000", lat, y_out);
      end
   endtask

   task automatic test_reset_mid_mac();
      int lat;
      bit seen;
      set_coefs(16'h4000, 16'h0000);
      set_taps(16'h1234, 16'h0000);
      run_once(lat);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || y_valid !== 1'b0 || y_out !== 16'h0000) begin
         failures++;
         $display("FAIL async_reset_mid: ready=%b busy=%b y_valid=%b y_out=%h, need 1 0 0 0000",
                  ready, busy, y_valid, y_out);
      end
      tick();
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (y_valid || !ready) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL no_valid_after_reset: activity=%b, need 0", seen);
      end
      set_taps(16'h7FFF, 16'h7FFF);
      run_once(lat);
      checks++;
      if (lat !== 9 || y_out !== 16'h0000) begin
         failures++;
         $display("FAIL coefs_cleared: lat=%0d y_out=%h, need 9 0000", lat, y_out);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      set_taps(16'h0000, 16'h0000);
      test_reset();
      test_latency();
      test_saturation();
      test_rounding();
      test_busy_rules();
      test_reset_mid_mac();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
